// File: rtl/axi_preload_burst_writer_pkg.sv
// Shared types and helpers for the preload burst writer.
// The AXI channel structs use the writer's default widths:
// 64-bit address, 64-bit data and 8-bit ID.
package axi_preload_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
    } axi_ax_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } axi_w_chan_t;

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] resp;
    } axi_b_chan_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_chan_t;

    typedef struct packed {
        axi_ax_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ax_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        axi_b_chan_t b;
        logic        r_valid;
        axi_r_chan_t r;
    } axi_rsp_t;

    // True when a beat address sits on the first byte of a 4 KiB page,
    // i.e. reaching it from the previous beat would cross the page.
    function automatic logic is_4k_boundary(input logic [11:0] addr_low);
        return (addr_low == 12'h000);
    endfunction

endpackage

// File: rtl/axi_preload_burst_writer_beat_buf.sv
// Beat buffer: Depth x DataWidth register FIFO that collects one burst.
// Entries are written in order; the read pointer walks them during the
// W phase; a clear empties the buffer once the burst has completed.
module axi_preload_beat_buf #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Depth     = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         i_clr,
    input  logic                         i_wr_en,
    input  logic [DataWidth-1:0]         i_wr_data,
    input  logic                         i_rd_en,
    output logic [DataWidth-1:0]         o_rd_data,
    output logic [$clog2(Depth):0]       o_count,
    output logic [$clog2(Depth)-1:0]     o_rd_ptr
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [DataWidth-1:0] r_mem [Depth];
    logic [CntW-1:0]      r_count;
    logic [PtrW-1:0]      r_rd_ptr;
    logic                 w_full;
    logic [PtrW-1:0]      w_wr_ptr;

    assign w_full   = (r_count == CntW'(Depth));
    assign w_wr_ptr = r_count[PtrW-1:0];

    // Storage: append accepted words at the fill position.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem <= '{default: '0};
        end else if (i_wr_en && !w_full) begin
            r_mem[w_wr_ptr] <= i_wr_data;
        end
    end

    // Fill count and read pointer; clear has priority over both.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en && !w_full) begin
                r_count <= r_count + CntW'(1);
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_rd_ptr  = r_rd_ptr;

endmodule

// File: rtl/axi_preload_burst_writer.sv
// AXI4 write master that coalesces contiguous preload words into INCR
// bursts (AW/W/B only; AR/R tied off). Bursts close when the buffer is
// full, on a non-contiguous word, before a 4 KiB crossing, on flush_i,
// or after an idle timeout.
module axi_preload_burst_writer
    import axi_preload_pkg::*;
#(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned IdWidth     = 8,
    parameter int unsigned MaxBurstLen = 16,
    parameter int unsigned IdleCycles  = 32,
    parameter type axi_req_t = axi_preload_pkg::axi_req_t,
    parameter type axi_rsp_t = axi_preload_pkg::axi_rsp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 word_valid_i,
    output logic                 word_ready_o,
    input  logic [AddrWidth-1:0] word_addr_i,
    input  logic [DataWidth-1:0] word_data_i,
    input  logic                 flush_i,
    output logic                 flush_done_o,
    output logic                 busy_o,
    output logic                 err_o,
    output logic [7:0]           err_cnt_o,
    output axi_req_t             axi_req_o,
    input  axi_rsp_t             axi_rsp_i
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffW      = $clog2(StrbWidth);
    localparam int unsigned PtrW      = $clog2(MaxBurstLen);
    localparam int unsigned CntW      = PtrW + 1;
    localparam int unsigned IdleW     = (IdleCycles > 0) ? $clog2(IdleCycles + 1) : 1;
    localparam logic [CntW-1:0]      CntMax  = CntW'(MaxBurstLen);
    localparam logic [IdleW-1:0]     IdleMax = IdleW'(IdleCycles);
    localparam logic [AddrWidth-1:0] OffMask = AddrWidth'(StrbWidth - 1);

    state_e                 r_state;
    state_e                 w_state_next;
    logic [AddrWidth-1:0]   r_base;
    logic [IdleW-1:0]       r_idle;
    logic                   r_flush_done;
    logic                   r_flush_served;
    logic                   r_err;
    logic [7:0]             r_err_cnt;

    logic [CntW-1:0]        w_cnt;
    logic [PtrW-1:0]        w_rd_ptr;
    logic [DataWidth-1:0]   w_rd_data;
    logic [AddrWidth-1:0]   w_word_addr;
    logic [AddrWidth:0]     w_off_ext;
    logic [AddrWidth:0]     w_next_ext;
    logic [AddrWidth-1:0]   w_next_addr;
    logic                   w_wrap;
    logic                   w_contig;
    logic                   w_same4k_viol;
    logic                   w_full;
    logic                   w_idle_hit;
    logic                   w_in_fill;
    logic                   w_word_ready;
    logic                   w_accept;
    logic                   w_trigger;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_w_last;
    logic                   w_b_hs;
    logic                   w_b_err;
    logic                   w_flush_done_set;
    logic                   w_unused;

    // Word address is beat aligned; the expected next address is
    // base + cnt*bytes, computed one bit wider so a wrap past the top of
    // the address space is seen as a break in contiguity.
    assign w_word_addr = word_addr_i & ~OffMask;
    assign w_off_ext   = (AddrWidth + 1)'(w_cnt) << OffW;
    assign w_next_ext  = {1'b0, r_base} + w_off_ext;
    assign w_next_addr = w_next_ext[AddrWidth-1:0];
    assign w_wrap      = w_next_ext[AddrWidth];

    assign w_in_fill     = (r_state == FILL);
    assign w_contig      = !w_wrap && (w_word_addr == w_next_addr);
    assign w_same4k_viol = (w_cnt != '0) && (w_wrap || is_4k_boundary(w_next_addr[11:0]));
    assign w_full        = (w_cnt == CntMax);
    assign w_idle_hit    = (IdleCycles != 32'd0) && (r_idle == IdleMax);

    assign w_word_ready = w_in_fill && (w_cnt < CntMax) && ((w_cnt == '0) || w_contig)
                          && !w_same4k_viol && !flush_i;
    assign w_accept     = word_valid_i && w_word_ready;

    // A word accepted in the same cycle as an idle trigger simply joins the
    // burst: AW length is taken from the count after this edge.
    assign w_trigger = w_in_fill && (w_cnt != '0)
                       && (w_full || (word_valid_i && !w_contig) || w_same4k_viol
                           || flush_i || w_idle_hit);

    assign w_aw_hs  = (r_state == ADDR) && axi_rsp_i.aw_ready;
    assign w_w_hs   = (r_state == DATA) && axi_rsp_i.w_ready;
    assign w_w_last = (CntW'(w_rd_ptr) == (w_cnt - CntW'(1)));
    assign w_b_hs   = (r_state == RESP) && axi_rsp_i.b_valid;
    assign w_b_err  = (axi_rsp_i.b.resp != AXI_RESP_OKAY);

    assign w_flush_done_set = w_in_fill && (w_cnt == '0) && flush_i && !r_flush_served;

    // Response fields this write-only master never looks at.
    assign w_unused = ^{axi_rsp_i.ar_ready, axi_rsp_i.r_valid, axi_rsp_i.r, axi_rsp_i.b.id};

    axi_preload_beat_buf #(
        .DataWidth (DataWidth),
        .Depth     (MaxBurstLen)
    ) u_beat_buf (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_clr     (w_b_hs),
        .i_wr_en   (w_accept),
        .i_wr_data (word_data_i),
        .i_rd_en   (w_w_hs && !w_w_last),
        .o_rd_data (w_rd_data),
        .o_count   (w_cnt),
        .o_rd_ptr  (w_rd_ptr)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: fill, address, data beats, write response.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL: begin
                if (w_trigger) begin
                    w_state_next = ADDR;
                end else begin
                    w_state_next = FILL;
                end
            end
            ADDR: begin
                if (w_aw_hs) begin
                    w_state_next = DATA;
                end else begin
                    w_state_next = ADDR;
                end
            end
            DATA: begin
                if (w_w_hs && w_w_last) begin
                    w_state_next = RESP;
                end else begin
                    w_state_next = DATA;
                end
            end
            RESP: begin
                if (w_b_hs) begin
                    w_state_next = FILL;
                end else begin
                    w_state_next = RESP;
                end
            end
            default: begin
                w_state_next = FILL;
            end
        endcase
    end

    // Burst base address, captured from the first word of each burst.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_base <= '0;
        end else if (w_accept && (w_cnt == '0)) begin
            r_base <= w_word_addr;
        end
    end

    // Idle counter: cycles in FILL holding data with no word offered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idle <= '0;
        end else if (!w_in_fill || (w_cnt == '0) || w_accept) begin
            r_idle <= '0;
        end else if (!word_valid_i && (r_idle != IdleMax)) begin
            r_idle <= r_idle + IdleW'(1);
        end
    end

    // Flush-done pulse, at most once per assertion of flush_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_flush_done   <= 1'b0;
            r_flush_served <= 1'b0;
        end else begin
            r_flush_done   <= w_flush_done_set;
            r_flush_served <= flush_i && (r_flush_served || w_flush_done_set);
        end
    end

    // Sticky error flag and saturating error counter from B responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else if (w_b_hs && w_b_err) begin
            r_err <= 1'b1;
            if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // AXI request: AW/W payloads come straight from registers so they stay
    // stable while waiting for ready; AR is idle and R is always accepted.
    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw.id    = '0;
        axi_req_o.aw.addr  = r_base;
        axi_req_o.aw.len   = 8'(w_cnt - CntW'(1));
        axi_req_o.aw.size  = 3'(OffW);
        axi_req_o.aw.burst = AXI_BURST_INCR;
        axi_req_o.aw.cache = 4'b0000;
        axi_req_o.aw.prot  = 3'b000;
        axi_req_o.aw_valid = (r_state == ADDR);
        axi_req_o.w.data   = w_rd_data;
        axi_req_o.w.strb   = '1;
        axi_req_o.w.last   = w_w_last;
        axi_req_o.w_valid  = (r_state == DATA);
        axi_req_o.b_ready  = (r_state == RESP);
        axi_req_o.ar_valid = 1'b0;
        axi_req_o.r_ready  = 1'b1;
    end

    assign word_ready_o = w_word_ready;
    assign flush_done_o = r_flush_done;
    assign busy_o       = (r_state != FILL) || (w_cnt != '0);
    assign err_o        = r_err;
    assign err_cnt_o    = r_err_cnt;

endmodule
